// File: rtl/trdb_pkg.sv
// Shared trace packet types, payload lengths and payload field offsets used by
// the trace encoder and decoder.
package trdb_pkg;

    typedef enum logic [1:0] {
        F_BRANCH_FULL = 2'd0,
        F_BRANCH_DIFF = 2'd1,
        F_ADDR_ONLY   = 2'd2,
        F_SYNC        = 2'd3
    } trdb_format_t;

    typedef enum logic [1:0] {
        SF_START     = 2'd0,
        SF_EXCEPTION = 2'd1,
        SF_CONTEXT   = 2'd2,
        SF_UNDEF     = 2'd3
    } trdb_subformat_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_EMIT    = 2'd3
    } trdb_dec_state_t;

    localparam logic [7:0] PLEN_BRANCH_FULL    = 8'd70;
    localparam logic [7:0] PLEN_ADDR_ONLY      = 8'd34;
    localparam logic [7:0] PLEN_SYNC_START     = 8'd36;
    localparam logic [7:0] PLEN_SYNC_CONTEXT   = 8'd36;
    localparam logic [7:0] PLEN_SYNC_EXCEPTION = 8'd42;

    // Bit offsets inside the payload, which begins at bit 8 of word 0.
    localparam int unsigned OFF_FORMAT      = 0;
    localparam int unsigned OFF_SUBFORMAT   = 2;
    localparam int unsigned OFF_BF_BRANCHES = 2;
    localparam int unsigned OFF_BF_MAP      = 7;
    localparam int unsigned OFF_BF_ADDR     = 38;
    localparam int unsigned OFF_AO_ADDR     = 2;
    localparam int unsigned OFF_SYNC_ADDR   = 4;
    localparam int unsigned OFF_EX_ECAUSE   = 4;
    localparam int unsigned OFF_EX_INTR     = 9;
    localparam int unsigned OFF_EX_ADDR     = 10;

    // ceil((plen + 8) / 32); only meaningful for plen within the accepted bound.
    function automatic logic [1:0] packet_words(input logic [7:0] plen);
        return 2'(({1'b0, plen} + 9'd39) >> 5);
    endfunction

endpackage

// File: rtl/trdb_packet_fields.sv
// Combinational field extraction and length check for one reassembled packet.
module trdb_packet_fields
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAXWORDS = 3
) (
    input  logic [32*MAXWORDS-1:0] buf_i,
    output trdb_format_t           format_o,
    output trdb_subformat_t        subformat_o,
    output logic [4:0]             branches_o,
    output logic [30:0]            branch_map_o,
    output logic [XLEN-1:0]        address_o,
    output logic [4:0]             ecause_o,
    output logic                   interrupt_o,
    output logic                   length_ok_o
);

    localparam int unsigned PW = 32*MAXWORDS - 8;

    logic [7:0]    plen;
    logic [PW-1:0] pl;
    logic          unused_tail;

    assign plen        = buf_i[7:0];
    assign pl          = buf_i[32*MAXWORDS-1:8];
    assign unused_tail = ^pl[PW-1:OFF_BF_ADDR+XLEN];

    always_comb begin
        format_o     = trdb_format_t'(pl[OFF_FORMAT +: 2]);
        subformat_o  = SF_UNDEF;
        branches_o   = '0;
        branch_map_o = '0;
        address_o    = '0;
        ecause_o     = '0;
        interrupt_o  = 1'b0;
        length_ok_o  = 1'b0;
        case (format_o)
            F_BRANCH_FULL: begin
                branches_o   = pl[OFF_BF_BRANCHES +: 5];
                branch_map_o = pl[OFF_BF_MAP +: 31];
                address_o    = pl[OFF_BF_ADDR +: XLEN];
                length_ok_o  = (plen == PLEN_BRANCH_FULL);
            end
            F_ADDR_ONLY: begin
                address_o   = pl[OFF_AO_ADDR +: XLEN];
                length_ok_o = (plen == PLEN_ADDR_ONLY);
            end
            F_SYNC: begin
                subformat_o = trdb_subformat_t'(pl[OFF_SUBFORMAT +: 2]);
                case (subformat_o)
                    SF_START: begin
                        address_o   = pl[OFF_SYNC_ADDR +: XLEN];
                        length_ok_o = (plen == PLEN_SYNC_START);
                    end
                    SF_CONTEXT: begin
                        address_o   = pl[OFF_SYNC_ADDR +: XLEN];
                        length_ok_o = (plen == PLEN_SYNC_CONTEXT);
                    end
                    SF_EXCEPTION: begin
                        ecause_o    = pl[OFF_EX_ECAUSE +: 5];
                        interrupt_o = pl[OFF_EX_INTR];
                        address_o   = pl[OFF_EX_ADDR +: XLEN];
                        length_ok_o = (plen == PLEN_SYNC_EXCEPTION);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/trdb_packet_decoder.sv
// Trace packet decoder: reassembles variable-length packets from a 32-bit word
// stream and presents length-checked, decoded fields on a valid/ready output.
module trdb_packet_decoder
    import trdb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAXWORDS = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            pkt_valid_o,
    input  logic            pkt_ready_i,
    output trdb_format_t    format_o,
    output trdb_subformat_t subformat_o,
    output logic [4:0]      branches_o,
    output logic [30:0]     branch_map_o,
    output logic [XLEN-1:0] address_o,
    output logic [4:0]      ecause_o,
    output logic            interrupt_o,
    output logic            err_o
);

    localparam logic [7:0] PLEN_MAX = 8'(32*MAXWORDS - 8);

    if (XLEN != 32) begin : g_xlen_check
        $error("trdb_packet_decoder: only XLEN = 32 is supported");
    end

    trdb_dec_state_t           state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [1:0]                nw_q, nw_d;
    logic                      err_q, err_d;
    logic                      live_q;
    logic [MAXWORDS-1:0][31:0] buf_q;
    logic                      wr_en;
    logic [1:0]                wr_idx;
    logic                      load;
    logic [7:0]                hdr_plen;

    trdb_format_t              f_format;
    trdb_subformat_t           f_subformat;
    logic [4:0]                f_branches;
    logic [30:0]               f_branch_map;
    logic [XLEN-1:0]           f_address;
    logic [4:0]                f_ecause;
    logic                      f_interrupt;
    logic                      f_length_ok;

    trdb_format_t              format_q;
    trdb_subformat_t           subformat_q;
    logic [4:0]                branches_q;
    logic [30:0]               branch_map_q;
    logic [XLEN-1:0]           address_q;
    logic [4:0]                ecause_q;
    logic                      interrupt_q;

    assign hdr_plen = data_i[7:0];

    trdb_packet_fields #(
        .XLEN     (XLEN),
        .MAXWORDS (MAXWORDS)
    ) u_fields (
        .buf_i        (buf_q),
        .format_o     (f_format),
        .subformat_o  (f_subformat),
        .branches_o   (f_branches),
        .branch_map_o (f_branch_map),
        .address_o    (f_address),
        .ecause_o     (f_ecause),
        .interrupt_o  (f_interrupt),
        .length_ok_o  (f_length_ok)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nw_d        = nw_q;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = cnt_q;
        load        = 1'b0;
        ready_o     = 1'b0;
        pkt_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // live_q keeps ready_o low until the first edge after reset release.
                ready_o = live_q;
                if (valid_i && live_q) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (hdr_plen == '0 || hdr_plen > PLEN_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        nw_d    = packet_words(hdr_plen);
                        cnt_d   = 2'd1;
                        state_d = (packet_words(hdr_plen) == 2'd1) ? S_CHECK : S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == nw_q - 2'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (f_length_ok) begin
                    load    = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                pkt_valid_o = 1'b1;
                if (pkt_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nw_q    <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nw_q    <= nw_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q        <= '0;
            format_q     <= F_ADDR_ONLY;
            subformat_q  <= SF_UNDEF;
            branches_q   <= '0;
            branch_map_q <= '0;
            address_q    <= '0;
            ecause_q     <= '0;
            interrupt_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                buf_q[wr_idx] <= data_i;
            end
            if (load) begin
                format_q     <= f_format;
                subformat_q  <= f_subformat;
                branches_q   <= f_branches;
                branch_map_q <= f_branch_map;
                address_q    <= f_address;
                ecause_q     <= f_ecause;
                interrupt_q  <= f_interrupt;
            end
        end
    end

    assign err_o        = err_q;
    assign format_o     = format_q;
    assign subformat_o  = subformat_q;
    assign branches_o   = branches_q;
    assign branch_map_o = branch_map_q;
    assign address_o    = address_q;
    assign ecause_o     = ecause_q;
    assign interrupt_o  = interrupt_q;

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Scoreboard bench for trdb_packet_decoder: packets are built from fields,
// expectations queued at drive time and compared as packets or errors appear.
module tb_trdb_packet_decoder;
    import trdb_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [31:0]     data_i = '0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic            pkt_valid_o;
    logic            pkt_ready_i = 1'b1;
    trdb_format_t    format_o;
    trdb_subformat_t subformat_o;
    logic [4:0]      branches_o;
    logic [30:0]     branch_map_o;
    logic [31:0]     address_o;
    logic [4:0]      ecause_o;
    logic            interrupt_o;
    logic            err_o;

    typedef struct {
        bit          is_err;
        logic [1:0]  fmt;
        logic [1:0]  sf;
        logic [4:0]  br;
        logic [30:0] map;
        logic [31:0] addr;
        logic [4:0]  ec;
        logic        intr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          neg_cyc = 0;
    int          last_hs = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_addr;
    logic [45:0] held_ctl;
    logic [95:0] pk;

    always #5 clk_i = ~clk_i;

    trdb_packet_decoder #(.XLEN(32), .MAXWORDS(3)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .pkt_valid_o  (pkt_valid_o),
        .pkt_ready_i  (pkt_ready_i),
        .format_o     (format_o),
        .subformat_o  (subformat_o),
        .branches_o   (branches_o),
        .branch_map_o (branch_map_o),
        .address_o    (address_o),
        .ecause_o     (ecause_o),
        .interrupt_o  (interrupt_o),
        .err_o        (err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] build(input logic [1:0] fmt, input logic [1:0] sf,
                                          input logic [4:0] br, input logic [30:0] map,
                                          input logic [31:0] addr, input logic [4:0] ec,
                                          input logic intr, input logic [7:0] plen);
        logic [87:0] p;
        logic [95:0] full, mask, junk;
        p = '0;
        p[1:0] = fmt;
        case (fmt)
            2'd0: begin p[6:2] = br; p[37:7] = map; p[69:38] = addr; end
            2'd2: p[33:2] = addr;
            2'd3: begin
                p[3:2] = sf;
                if (sf == 2'd1) begin p[8:4] = ec; p[9] = intr; p[41:10] = addr; end
                else p[35:4] = addr;
            end
            default: ;
        endcase
        full = {p, plen};
        mask = (96'd1 << (int'(plen) + 8)) - 96'd1;
        junk = {$urandom, $urandom, $urandom};
        return (full & mask) | (junk & ~mask);
    endfunction

    task automatic send_raw(input logic [95:0] w, input int nw, input int gap);
        int waited;
        for (int i = 0; i < nw; i++) begin
            waited = 0;
            @(negedge clk_i);
            valid_i = 1'b1;
            data_i  = w[32*i +: 32];
            while (!ready_o && waited < 100) begin
                @(negedge clk_i);
                waited++;
            end
            if (!ready_o) begin
                check("word_accept_wait", ready_o, 1);
                valid_i = 1'b0;
                return;
            end
            last_hs = neg_cyc;
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
            repeat (gap) @(negedge clk_i);
        end
    endtask

    task automatic send_pkt(input logic [1:0] fmt, input logic [1:0] sf, input logic [4:0] br,
                            input logic [30:0] map, input logic [31:0] addr, input logic [4:0] ec,
                            input logic intr, input logic [7:0] plen, input bit is_err,
                            input int gap);
        exp_t e;
        int   nw;
        bit   is_exc;
        is_exc   = (fmt == F_SYNC) && (sf == SF_EXCEPTION);
        e.is_err = is_err;
        e.fmt    = fmt;
        e.sf     = (fmt == F_SYNC) ? sf : SF_UNDEF;
        e.br     = (fmt == F_BRANCH_FULL) ? br : 5'd0;
        e.map    = (fmt == F_BRANCH_FULL) ? map : 31'd0;
        e.addr   = addr;
        e.ec     = is_exc ? ec : 5'd0;
        e.intr   = is_exc ? intr : 1'b0;
        sb.push_back(e);
        nw = (plen == 8'd0 || plen > 8'd88) ? 1 : (int'(plen) + 8 + 31) / 32;
        send_raw(build(fmt, sf, br, map, addr, ec, intr, plen), nw, gap);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, ready_o, 0);
        check({tag, "_pkt_valid"}, pkt_valid_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_format"}, format_o, F_ADDR_ONLY);
        check({tag, "_subformat"}, subformat_o, SF_UNDEF);
        check({tag, "_branches"}, branches_o, 0);
        check({tag, "_branch_map"}, branch_map_o, 0);
        check({tag, "_address"}, address_o, 0);
        check({tag, "_ecause"}, ecause_o, 0);
        check({tag, "_interrupt"}, interrupt_o, 0);
    endtask

    always @(negedge clk_i) begin
        neg_cyc <= neg_cyc + 1;
        if (!rst_ni) begin
            prev_valid = 1'b0;
        end else begin
            if (err_o) begin
                check("sb_has_entry_for_err", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("err_expected", err_o, mon_e.is_err);
                end
            end
            if (pkt_valid_o) begin
                check("ready_low_in_emit", ready_o, 0);
                if (!prev_valid) begin
                    check("latency", neg_cyc - last_hs, 2);
                end else begin
                    check("stable_addr", address_o, held_addr);
                    check("stable_ctl", {format_o, subformat_o, branches_o, branch_map_o,
                                         ecause_o, interrupt_o}, held_ctl);
                end
                held_addr = address_o;
                held_ctl  = {format_o, subformat_o, branches_o, branch_map_o, ecause_o, interrupt_o};
                if (pkt_ready_i) begin
                    check("sb_has_entry_for_pkt", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("pkt_expected", pkt_valid_o, !mon_e.is_err);
                        if (!mon_e.is_err) begin
                            check("format", format_o, mon_e.fmt);
                            check("subformat", subformat_o, mon_e.sf);
                            check("branches", branches_o, mon_e.br);
                            check("branch_map", branch_map_o, mon_e.map);
                            check("address", address_o, mon_e.addr);
                            check("ecause", ecause_o, mon_e.ec);
                            check("interrupt", interrupt_o, mon_e.intr);
                        end
                    end
                end
            end
            prev_valid = pkt_valid_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        check_reset("por");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_release", ready_o, 1);

        send_pkt(F_ADDR_ONLY, SF_UNDEF, 5'd0, 31'd0, 32'h8000_0010, 5'd0, 1'b0, 8'd34, 1'b0, 0);
        wait_idle();
        send_pkt(F_BRANCH_FULL, SF_UNDEF, 5'd31, 31'h5555_5555, 32'h1C00_0080, 5'd0, 1'b0,
                 8'd70, 1'b0, 2);
        wait_idle();

        // Exception packet held under backpressure while the next header waits.
        pkt_ready_i = 1'b0;
        send_pkt(F_SYNC, SF_EXCEPTION, 5'd0, 31'd0, 32'h0000_0100, 5'd11, 1'b1, 8'd42, 1'b0, 0);
        fork
            send_pkt(F_SYNC, SF_START, 5'd0, 31'd0, 32'hDEAD_BEE0, 5'd0, 1'b0, 8'd36, 1'b0, 0);
            begin
                n = 0;
                while (!pkt_valid_o && n < 100) begin
                    @(negedge clk_i);
                    n++;
                end
                check("exception_valid_seen", pkt_valid_o, 1);
                repeat (5) @(posedge clk_i);
                #1;
                pkt_ready_i = 1'b1;
            end
        join
        wait_idle();

        send_pkt(F_SYNC, SF_CONTEXT, 5'd0, 31'd0, 32'h1234_5678, 5'd0, 1'b0, 8'd36, 1'b0, 1);
        wait_idle();

        send_pkt(F_SYNC, SF_START, 5'd0, 31'd0, 32'h4000_0000, 5'd0, 1'b0, 8'd34, 1'b1, 0);
        send_pkt(F_ADDR_ONLY, SF_UNDEF, 5'd0, 31'd0, 32'h0, 5'd0, 1'b0, 8'd0, 1'b1, 0);
        send_pkt(F_ADDR_ONLY, SF_UNDEF, 5'd0, 31'd0, 32'hCAFE_0004, 5'd0, 1'b0, 8'd34, 1'b0, 0);
        wait_idle();

        send_pkt(F_ADDR_ONLY, SF_UNDEF, 5'd0, 31'd0, 32'h0, 5'd0, 1'b0, 8'd89, 1'b1, 0);
        send_pkt(F_BRANCH_DIFF, SF_UNDEF, 5'd0, 31'd0, 32'h0, 5'd0, 1'b0, 8'd34, 1'b1, 0);
        send_pkt(F_SYNC, SF_UNDEF, 5'd0, 31'd0, 32'h0, 5'd0, 1'b0, 8'd36, 1'b1, 0);
        send_pkt(F_BRANCH_FULL, SF_UNDEF, 5'd1, 31'h7FFF_FFFF, 32'hFFFF_FFFC, 5'd0, 1'b0,
                 8'd70, 1'b0, 0);
        wait_idle();

        // Abort a 3-word packet after its second word with an asynchronous reset.
        pk = build(F_BRANCH_FULL, SF_UNDEF, 5'd7, 31'h0123_4567, 32'h89AB_CDEF, 5'd0, 1'b0, 8'd70);
        send_raw(pk, 2, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(negedge clk_i);
        check_reset("mid_reset_hold");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_mid_release", ready_o, 1);
        send_pkt(F_ADDR_ONLY, SF_UNDEF, 5'd0, 31'd0, 32'h8000_0010, 5'd0, 1'b0, 8'd34, 1'b0, 0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trdb_packet_decoder.md
Name: trdb_packet_decoder

Overview:
- Receiving end of the trace packet protocol. It consumes the 32-bit word stream written by the trace encoder's packet emitter.
- Reassembles each variable-length packet, checks its length against its format/subformat, and presents decoded fields on a valid/ready output.
- Sits in the debug-side unpacker and in the verification environment as a hardware reference decoder.

Parameters:
- XLEN, 32, address width; only 32 is supported, elaboration assertion otherwise.
- MAXWORDS, 3, maximum packet size in 32-bit words.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_i  in  32  packet word stream
- valid_i  in  1  data_i valid
- ready_o  out  1  decoder accepts data_i
- pkt_valid_o  out  1  decoded packet available
- pkt_ready_i  in  1  consumer accepts packet
- format_o  out  trdb_format_t  packet format
- subformat_o  out  trdb_subformat_t  sync subformat; SF_UNDEF for non-sync packets
- branches_o  out  5  branch count (F_BRANCH_FULL)
- branch_map_o  out  31  branch map (F_BRANCH_FULL)
- address_o  out  XLEN  address; context value for SF_CONTEXT
- ecause_o  out  5  exception cause (SF_EXCEPTION)
- interrupt_o  out  1  interrupt flag (SF_EXCEPTION)
- err_o  out  1  one-cycle pulse: malformed packet dropped

Behaviour:
- Word 0, bits [7:0]: PLEN, the payload length in bits.
- Payload starts at bit 8 of word 0 and continues LSB-first through the following words. Unused trailing bits are ignored.
- Packet word count is NW = ceil((PLEN+8)/32).
- Payload layout (payload bit offsets):
  - format [1:0].
  - F_BRANCH_FULL: branches [6:2], branch_map [37:7], address [69:38]; PLEN = 70.
  - F_ADDR_ONLY: address [33:2]; PLEN = 34.
  - F_SYNC: subformat [3:2].
    - SF_START: address [35:4]; PLEN = 36.
    - SF_CONTEXT: context [35:4] on address_o; PLEN = 36.
    - SF_EXCEPTION: ecause [8:4], interrupt [9], address [41:10]; PLEN = 42.
  - F_BRANCH_DIFF and SF_UNDEF are unsupported and treated as errors.
- FSM states:
  - IDLE: ready_o = 1. A header handshake (valid_i & ready_o) stores word 0 and latches NW.
    - PLEN = 0 or PLEN > 32*MAXWORDS-8: pulse err_o next cycle, remain in IDLE. Only that one word is consumed.
    - NW = 1: go to CHECK.
    - Otherwise: go to COLLECT.
  - COLLECT: ready_o = 1. Each handshake stores a word at the word counter index and increments the counter. On the word with index NW-1, go to CHECK.
  - CHECK (1 cycle): ready_o = 0. Compare PLEN with the expected length for the decoded format/subformat.
    - Match: register the fields, go to EMIT.
    - Mismatch or unsupported encoding: pulse err_o, go to IDLE.
  - EMIT: ready_o = 0, pkt_valid_o = 1, outputs held stable. On pkt_ready_i, go to IDLE in the next cycle.
- Latency: pkt_valid_o rises 2 cycles after the last word handshake (the CHECK cycle, then EMIT).
- Throughput: the minimum gap between packets is 1 idle-accept cycle after the EMIT handshake.
- No bubble requirement on the input; valid_i may drop at any time in COLLECT. The word counter holds its value.
- Output fields of a non-applicable format are driven to 0.
- Reset, including asynchronously mid-packet:
  - state IDLE; counter 0; buffer cleared.
  - pkt_valid_o = 0, err_o = 0, ready_o = 0 during reset, then 1 from the first cycle after release.
  - format_o = F_ADDR_ONLY, subformat_o = SF_UNDEF, all other outputs 0.
- Word count never exceeds MAXWORDS, guaranteed by the PLEN bound check.

Decomposition:
- trdb_pkg gains:
  - trdb_format_t and trdb_subformat_t, shared with the encoder.
  - PLEN constants: PLEN_BRANCH_FULL = 70, PLEN_ADDR_ONLY = 34, PLEN_SYNC_START = 36, PLEN_SYNC_CONTEXT = 36, PLEN_SYNC_EXCEPTION = 42.
  - Field offset localparams.
- One sub-module, trdb_packet_fields: purely combinational. Takes the 96-bit buffer and produces the fields plus a length_ok flag. The top-level module holds the FSM, word counter and registers.

Test Plan:
- Addr-only packet:
  - Stimulus: PLEN = 34, format F_ADDR_ONLY, address 0x8000_0010, 2 words, pkt_ready_i = 1.
  - Required: one pkt_valid_o pulse 2 cycles after word 1; format_o = F_ADDR_ONLY, address_o = 0x8000_0010, subformat_o = SF_UNDEF.
- Branch-full packet:
  - Stimulus: branches = 31, branch_map = 0x5555_5555 & 31-bit mask, address 0x1C00_0080, 3 words, with valid_i gaps of 2 cycles between words.
  - Required: all three fields exact; no err_o.
- Sync exception with backpressure:
  - Stimulus: ecause = 11, interrupt = 1, address 0x0000_0100; pkt_ready_i held low 5 cycles.
  - Required: pkt_valid_o stays high with stable outputs; ready_o = 0 throughout; next header accepted only after the handshake.
- Malformed packets:
  - Stimulus: PLEN = 34 with format F_SYNC/SF_START.
    - Required: 2 words consumed, err_o pulses once, no pkt_valid_o.
  - Stimulus: PLEN = 0.
    - Required: 1 word consumed, err_o pulses.
  - Stimulus: a valid packet immediately afterwards.
    - Required: it decodes correctly.
- Reset mid-packet:
  - Stimulus: assert rst_ni low after word 1 of a 3-word packet, release, then send a fresh addr-only packet.
  - Required: all outputs at reset values while reset is low; the fresh packet decodes correctly.
